// File: rtl/fsm_var_id_matcher_pkg.sv
// Shared types and constants for the serial ID-frame matcher.
package fsm_var_id_matcher_pkg;

  localparam int FRAME_W = 4;
  localparam int CNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    CHECK = 2'd2
  } state_t;

  // A frame is accepted if it equals either configured ID.
  function automatic logic id_match(input logic [FRAME_W-1:0] frame,
                                    input logic [FRAME_W-1:0] id_a,
                                    input logic [FRAME_W-1:0] id_b);
    return (frame == id_a) || (frame == id_b);
  endfunction

endpackage

// File: rtl/fsm_var_id_matcher_shifter.sv
// MSB-first frame assembler: bit counter selects which frame bit the next
// serial sample lands in; done flags the sample that completes the frame.
module serial_frame_shifter
  import fsm_var_id_matcher_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,   // first sample of a frame, goes to MSB
  input  logic               shift,  // subsequent samples
  input  logic               clear,  // discard a partial frame
  input  logic               din,
  output logic [FRAME_W-1:0] frame,
  output logic               done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pos;

  // Sample with count k lands in bit FRAME_W-1-k (MSB first).
  assign pos  = CNT_W'(FRAME_W-1) - cnt;
  assign done = shift && (cnt == CNT_W'(FRAME_W-1));

  // Frame/counter update; counter wraps to 0 after the last bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frame <= '0;
      cnt   <= '0;
    end else if (load) begin
      frame <= {din, {(FRAME_W-1){1'b0}}};
      cnt   <= CNT_W'(1);
    end else if (shift) begin
      frame[pos] <= din;
      cnt        <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_var_id_matcher.sv
// Serial ID-frame receiver: collects 4-bit frames while start is high and
// pulses hit when a completed frame matches ID_1 or ID_2.
module fsm_var_id_matcher
  import fsm_var_id_matcher_pkg::*;
#(
  parameter int ID_1 = 1,
  parameter int ID_2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in,
  output logic               hit,
  output logic [FRAME_W-1:0] out
);

  // IDs wider than a frame are truncated to the frame width.
  localparam logic [FRAME_W-1:0] ID1_T = FRAME_W'(ID_1);
  localparam logic [FRAME_W-1:0] ID2_T = FRAME_W'(ID_2);

  state_t             state;
  logic               load;
  logic               shift;
  logic               clear;
  logic               done;
  logic [FRAME_W-1:0] frame;

  // Shifter controls decoded from the current state and the enable level.
  assign load  = (state == IDLE) &&  start;
  assign shift = (state == RX)   &&  start;
  assign clear = (state == RX)   && !start;

  serial_frame_shifter u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .clear (clear),
    .din   (in),
    .frame (frame),
    .done  (done)
  );

  // Matcher FSM with registered hit/out; CHECK lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hit   <= 1'b0;
      out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          hit <= 1'b0;
          if (start) state <= RX;
        end
        RX: begin
          hit <= 1'b0;
          if (!start)    state <= IDLE;   // abort, partial frame dropped
          else if (done) state <= CHECK;
        end
        CHECK: begin
          out   <= frame;
          hit   <= id_match(frame, ID1_T, ID2_T);
          state <= IDLE;
        end
        default: begin
          hit   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_var_id_matcher.sv
// Randomized + directed bench against a queue-based frame model.
module tb_fsm_var_id_matcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in = 1'b0;
  logic       hit_a, hit_b;
  logic [3:0] out_a, out_b;

  int n_chk = 0;
  int n_err = 0;

  // Model state: bits collected so far in the current frame.
  bit         q[$];
  bit         pend = 0;
  logic [3:0] m_out = 4'd0;
  bit         m_hit_a = 0;
  bit         m_hit_b = 0;

  always #5 clk = ~clk;

  fsm_var_id_matcher dut_a (
    .clk(clk), .rst(rst), .start(start), .in(in), .hit(hit_a), .out(out_a)
  );

  // 17 truncates to 1; both IDs equal behaves as a single ID.
  fsm_var_id_matcher #(.ID_1(17), .ID_2(17)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in(in), .hit(hit_b), .out(out_b)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level reference: after 4 accepted bits the next edge publishes.
  task automatic model_edge(input bit r, input bit s, input bit d);
    logic [3:0] f;
    if (r) begin
      q.delete(); pend = 0; m_out = 4'd0; m_hit_a = 0; m_hit_b = 0;
    end else if (pend) begin
      f = {q[0], q[1], q[2], q[3]};
      m_out   = f;
      m_hit_a = (f == 4'd1) || (f == 4'd2);
      m_hit_b = (f == (17 % 16));
      q.delete(); pend = 0;
    end else begin
      m_hit_a = 0; m_hit_b = 0;
      if (s) begin
        q.push_back(d);
        if (q.size() == 4) pend = 1;
      end else begin
        q.delete();
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit d);
    rst = r; start = s; in = d;
    @(posedge clk);
    model_edge(r, s, d);
    #1;
    check("out_a", out_a, m_out);
    check("hit_a", {3'b0, hit_a}, {3'b0, m_hit_a});
    check("out_b", out_b, m_out);
    check("hit_b", {3'b0, hit_b}, {3'b0, m_hit_b});
  endtask

  task automatic send_frame(input logic [3:0] f);
    for (int i = 3; i >= 0; i--) step(0, 1, f[i]);
    step(0, 1, 0);   // check edge, inputs ignored
    check("frame_out", out_a, f);
  endtask

  initial begin
    // 1. reset with start/in high
    step(1, 1, 1);
    step(1, 1, 1);
    check("rst_out", out_a, 4'd0);
    check("rst_hit", {3'b0, hit_a}, 4'd0);
    // 2. ID_1 match, hit for one cycle
    send_frame(4'b0001);
    check("id1_hit", {3'b0, hit_a}, 4'd1);
    step(0, 0, 0);
    check("id1_hit_clr", {3'b0, hit_a}, 4'd0);
    // 3. ID_2 match, then a non-match
    send_frame(4'b0010);
    check("id2_hit", {3'b0, hit_a}, 4'd1);
    send_frame(4'b0011);
    check("nomatch_hit", {3'b0, hit_a}, 4'd0);
    // 4. continuous start, constant in
    for (int k = 0; k < 15; k++) step(0, 1, 1);
    check("ones_out", out_a, 4'hF);
    for (int k = 0; k < 15; k++) step(0, 1, 0);
    check("zeros_out", out_a, 4'h0);
    // 5. abort after 2 bits, then fresh frame
    send_frame(4'b0011);
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
    step(0, 0, 0);
    check("abort_out", out_a, 4'b0011);
    check("abort_hit", {3'b0, hit_a}, 4'd0);
    // abort exactly on the 4th sample edge
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 0, 1);
    step(0, 0, 0);
    check("late_abort_out", out_a, 4'b0011);
    send_frame(4'b0010);
    check("post_abort_hit", {3'b0, hit_a}, 4'd1);
    // 6. mid-frame reset
    step(0, 1, 1); step(0, 1, 1); step(1, 1, 1);
    check("midrst_out", out_a, 4'd0);
    check("midrst_hit", {3'b0, hit_a}, 4'd0);
    // randomized traffic
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_var_id_matcher.md
Name: fsm_var_id_matcher

Overview:
- Serial ID-frame receiver/matcher for the thermostat house system.
- While `start` is high, it samples `in` serially into 4-bit frames (MSB first).
- Each completed frame is compared with two parameterised IDs. `hit` pulses on a match and `out` holds the last completed frame.
- Sits between a serial sensor/keypad line and the alarm/rest control logic.

Parameters:
- ID_1, default 1, first accepted 4-bit ID (legal range 0..15).
- ID_2, default 2, second accepted 4-bit ID (legal range 0..15; may equal ID_1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level enable; frame reception runs only while high.
- in  input  1  serial data bit, sampled on rising clk edges.
- hit  output  1  registered one-cycle pulse: last frame matched ID_1 or ID_2.
- out  output  4  registered last completed frame value, held between frames.

Behaviour:
- One clock domain; synchronous active-high reset. Reset has priority over all other inputs.
- Reset values:
  - state=IDLE, bit counter=0, shift register=0.
  - hit=0, out=4'b0000.
- States: IDLE, RX, CHECK.
- IDLE:
  - If start=1 at an edge: sample in as bit 3, set cnt=1, go to RX.
  - Otherwise stay in IDLE with hit=0.
- RX:
  - At each edge with start=1, shift in the next bit (MSB first) and increment cnt.
  - The edge that samples bit 0 (4th sample) moves to CHECK.
  - If start=0 at any RX edge: abort to IDLE, discard the partial frame, cnt=0; out is unchanged and hit stays 0.
- CHECK (exactly one cycle, start ignored):
  - At the edge leaving CHECK: out<=frame; hit<=(frame==ID_1)||(frame==ID_2); state goes to IDLE.
- Timing and latency:
  - hit and out update one edge after the 4th sampling edge.
  - hit is high for exactly one cycle and is cleared at the next edge.
- Back-to-back frames:
  - If start stays high, the first bit of the next frame is sampled on the edge after the CHECK edge.
  - The frame period is therefore 5 clocks: 4 sample edges plus 1 check edge.
- Simultaneous events: start falling on the edge that would sample bit 0 counts as an abort (no CHECK).
- ID_1==ID_2 is legal and behaves as a single ID.
- Parameters are truncated to 4 bits.
- No X propagation: all registers have explicit reset and a defined next state; unreachable state encodings go to IDLE.

Decomposition:
- Shared package holds:
  - FRAME_W=4.
  - State enum {IDLE, RX, CHECK}.
  - CNT_W=2 (counter width).
- Optional sub-module `serial_frame_shifter`: FRAME_W-bit MSB-first shift register plus bit counter, with load/clear/done. The matcher FSM stays in the top.

Test Plan:
1. Reset: rst=1 for 2 cycles with start=1 and in=1 -> hit=0, out=0000, no frame captured. Release rst -> reception starts on the next edge.
2. ID_1 match (ID_1=1, ID_2=2): start high, in = 0,0,0,1 over 4 edges -> next edge out=0001 and hit=1 for exactly one cycle.
3. ID_2 match: serial 0,0,1,0 -> out=0010, hit pulse. Then serial 0,0,1,1 -> out=0011, hit stays 0.
4. Continuous start, constant in:
   - in=1 -> out=1111 every 5 cycles, hit never asserted.
   - Then in=0 -> out=0000, hit never asserted.
5. Abort: start drops after 2 bits of a 0001 frame -> out keeps its previous value, no hit. Reassert start -> a fresh 4-bit frame 0010 gives hit.
6. Mid-frame reset: rst=1 during RX -> state IDLE, out=0000, hit=0 on the next edge.
